// File: rtl/seg_scan_controller.sv
`timescale 1ns/1ps
// Multiplexed N-digit seven-segment scanner: PWM brightness, per-digit DP, frame-coherent capture.
// Define LEADING_ZERO_BLANK_EN to blank digits above the most-significant nonzero nibble.
module seg_scan_controller #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 131072,
    parameter int DUTY_BITS  = 3
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic [4*NUM_DIGITS-1:0] adata,
    input  logic [4*NUM_DIGITS-1:0] bdata,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [DUTY_BITS-1:0]    brightness,
    output logic [NUM_DIGITS-1:0]   select,
    output logic [7:0]              segment,
    output logic                    frame_tick
);

    localparam int CNT_W    = $clog2(SCAN_DIV);
    localparam int DIG_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOT_LEN = SCAN_DIV >> DUTY_BITS;

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0] DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W:0]   PHASE_LEN  = (CNT_W + 1)'(SLOT_LEN);

    // Active-low a..g pattern for one hex nibble.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0000100;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;
            4'hD: glyph = 7'b1000010;
            4'hE: glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d;
    logic [DIG_W-1:0]        digit_q, digit_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   select_q, select_d;
    logic [7:0]              segment_q, segment_d;
    logic                    frame_tick_q, frame_tick_d;

    logic [4*NUM_DIGITS-1:0] src;
    logic                    slot_wrap;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [NUM_DIGITS-1:0]   sel_lit;
    logic [3:0]              nibble;
    logic                    dp_bit;
    logic                    blank_bit;
    logic [CNT_W:0]          lit_limit;
    logic                    lit;

    // Scan counters and frame-coherent capture of the display source.
    always_comb begin
        src          = (bdata != '0) ? bdata : adata;
        slot_wrap    = (slot_cnt_q == SLOT_LAST);
        frame_end    = slot_wrap && (digit_q == DIGIT_LAST);
        slot_cnt_d   = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        digit_d      = digit_q;
        if (slot_wrap) begin
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
        end
        shadow_d     = frame_end ? src : shadow_q;
        frame_tick_d = frame_end;
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;

    // NOTE: blocking assignments here build a running AND from the top digit down;
    // every output is assigned before any branch so no latch is inferred.
    always_comb begin
        zero_run  = 1'b1;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (shadow_q[4*i +: 4] == 4'h0);
            blank_vec[i] = zero_run && (i != 0) && !dp_mask[i];
        end
    end
`else
    assign blank_vec = '0;
`endif

    // Pick the current digit's nibble/DP/anode, then gate by the PWM phase.
    always_comb begin
        nibble    = 4'h0;
        dp_bit    = 1'b0;
        blank_bit = 1'b0;
        sel_lit   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_q == DIG_W'(i)) begin
                nibble                   = shadow_q[4*i +: 4];
                dp_bit                   = dp_mask[i];
                blank_bit                = blank_vec[i];
                sel_lit[NUM_DIGITS-1-i]  = 1'b0;
            end
        end

        // phase <= brightness  <=>  slot_cnt < (brightness + 1) * SLOT_LEN
        lit_limit = (CNT_W + 1)'(brightness) * PHASE_LEN + PHASE_LEN;
        lit       = ({1'b0, slot_cnt_q} < lit_limit);

        select_d  = '1;
        segment_d = 8'hFF;
        if (lit) begin
            select_d = sel_lit;
            if (!blank_bit) begin
                segment_d = {~dp_bit, glyph(nibble)};
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values. The shadow is loaded with live data during clear rather
    // than zeroed, so the first frame after reset already shows the source.
    always_ff @(posedge clk) begin
        if (clear) begin
            slot_cnt_q   <= '0;
            digit_q      <= '0;
            shadow_q     <= src;
            select_q     <= '1;
            segment_q    <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            digit_q      <= digit_d;
            shadow_q     <= shadow_d;
            select_q     <= select_d;
            segment_q    <= segment_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign select     = select_q;
    assign segment    = segment_q;
    assign frame_tick = frame_tick_q;

endmodule
